// File: rtl/mgt01_divide_unit.sv
// mgt01_divide_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per enabled cycle.
// Optional macro MGT01_DIV_EARLY_OUT_EN: zero-divisor/overflow requests skip the iteration phase.
package mgt01_divide_unit_pkg;
  typedef enum logic [1:0] {DIV_, DIVU_, REM_, REMU_} div_ops_e;
  typedef enum logic {FREE, BUSY} fu_state_e;
endpackage

module mgt01_divide_unit
  import mgt01_divide_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  div_ops_e        operation_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            div_by_zero_o,
  output fu_state_e       fu_state_o
);
  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_e;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_e          r_state, w_next;
  div_ops_e        r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_dvd, r_neg_dvs, r_zero, r_ovf, r_valid, r_dbz;
  logic [XLEN-1:0] r_dvd, r_dvs, r_quo, r_rem, r_result;
  logic            w_signed, w_dvd_neg, w_dvs_neg, w_zero, w_ovf, w_early;
  logic [XLEN-1:0] w_dvd_abs, w_q, w_r, w_quo, w_remf, w_res;
  logic [XLEN:0]   w_shift, w_trial;
  assign w_signed  = (operation_i == DIV_) || (operation_i == REM_);
  assign w_dvd_neg = w_signed & dividend_i[XLEN-1];
  assign w_dvs_neg = w_signed & divisor_i[XLEN-1];
  assign w_dvd_abs = w_dvd_neg ? -dividend_i : dividend_i;
  assign w_zero    = (divisor_i == '0);
  assign w_ovf     = w_signed & (dividend_i == MIN) & (&divisor_i);
`ifdef MGT01_DIV_EARLY_OUT_EN
  assign w_early   = w_zero | w_ovf;
`else
  assign w_early   = 1'b0;
`endif
  // r_quo starts as |dividend| and shifts out its MSB while quotient bits shift in
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_q     = (r_neg_dvd ^ r_neg_dvs) ? -r_quo : r_quo;
  assign w_r     = r_neg_dvd ? -r_rem : r_rem;
  assign w_quo   = r_zero ? '1 : r_ovf ? MIN : w_q;
  assign w_remf  = r_zero ? r_dvd : r_ovf ? '0 : w_r;
  assign w_res   = (r_op == DIV_ || r_op == DIVU_) ? w_quo : w_remf;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else if (clk_en_i) r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_i ? (w_early ? FINISH : ITER) : IDLE;
      ITER:    w_next = (r_cnt == CW'(XLEN-1)) ? FINISH : ITER;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb fu_state_o = (r_state == IDLE) ? FREE : BUSY;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_op      <= DIV_;
      r_neg_dvd <= 1'b0;
      r_neg_dvs <= 1'b0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (clk_en_i) begin
      r_valid <= (r_state == FINISH);
      if (r_state == IDLE && start_i) begin
        r_cnt     <= '0;
        r_op      <= operation_i;
        r_neg_dvd <= w_dvd_neg;
        r_neg_dvs <= w_dvs_neg;
        r_zero    <= w_zero;
        r_ovf     <= w_ovf;
        r_dvd     <= dividend_i;
        r_dvs     <= w_dvs_neg ? -divisor_i : divisor_i;
        r_quo     <= w_dvd_abs;
        r_rem     <= '0;
      end else if (r_state == ITER) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
      end else if (r_state == FINISH) begin
        r_result <= w_res;
        r_dbz    <= r_zero;
      end
    end
  end
  assign result_o      = r_result;
  assign valid_o       = r_valid;
  assign div_by_zero_o = r_dbz;
endmodule

// File: tb/tb_mgt01_divide_unit.sv
// tb_mgt01_divide_unit: directed self-checking bench for mgt01_divide_unit.
module tb_mgt01_divide_unit;
  import mgt01_divide_unit_pkg::*;
`ifdef MGT01_DIV_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif
  logic        clk_i = 1'b0, rst_i = 1'b1, clk_en_i = 1'b1, start_i = 1'b0;
  logic [31:0] dividend_i = '0, divisor_i = '0, result_o;
  div_ops_e    operation_i = DIVU_;
  logic        valid_o, div_by_zero_o;
  fu_state_e   fu_state_o;
  int          n_checks = 0, n_fail = 0;
  mgt01_divide_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .start_i(start_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .operation_i(operation_i),
    .result_o(result_o), .valid_o(valid_o), .div_by_zero_o(div_by_zero_o),
    .fu_state_o(fu_state_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk_i); #1;
      n++;
      if (valid_o) break;
    end
  endtask
  task automatic accept(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
    operation_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
    operation_i = div_ops_e'(op ^ 2'b10);
  endtask
  task automatic run_op(input string tag, input div_ops_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic dbz, input int lat);
    int n;
    accept(op, a, b);
    check({tag, "_busy"}, 32'(fu_state_o), 32'(BUSY));
    wait_valid(n);
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, result_o, exp);
    check({tag, "_dbz"}, 32'(div_by_zero_o), 32'(dbz));
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_state", 32'(fu_state_o), 32'(FREE));
    check("rst_res", result_o, 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_dbz", 32'(div_by_zero_o), 32'h0);
    run_op("divu", DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run_op("remu", REMU_, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    run_op("div_neg", DIV_, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
    run_op("rem_neg", REM_, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
    run_op("div_negdvs", DIV_, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    run_op("rem_negdvs", REM_, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 33);
    run_op("div_z", DIV_, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, SPL);
    run_op("remu_z", REMU_, 32'd5, 32'd0, 32'd5, 1'b1, SPL);
    run_op("rem_z", REM_, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b1, SPL);
    run_op("divu_z", DIVU_, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1, SPL);
    run_op("div_ovf", DIV_, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, SPL);
    run_op("rem_ovf", REM_, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, SPL);
    run_op("divu_big", DIVU_, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 33);
    @(posedge clk_i); #1;
    check("pulse_end", 32'(valid_o), 32'h0);
    // freeze mid-iteration while a stray start arrives
    accept(DIVU_, 32'd1000, 32'd3);
    repeat (16) @(posedge clk_i);
    #1 clk_en_i = 1'b0;
    operation_i = DIV_; dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    check("frz_res", result_o, 32'h0);
    check("frz_state", 32'(fu_state_o), 32'(BUSY));
    start_i = 1'b0; clk_en_i = 1'b1;
    wait_valid(n);
    check("frz_lat", n, 17);
    check("frz_res_done", result_o, 32'd333);
    @(posedge clk_i); #1;
    check("frz_pulse", 32'(valid_o), 32'h0);
    check("frz_noqueue", 32'(fu_state_o), 32'(FREE));
    // reset mid-iteration
    accept(DIVU_, 32'd1000, 32'd3);
    repeat (16) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    check("mrst_state", 32'(fu_state_o), 32'(FREE));
    check("mrst_res", result_o, 32'h0);
    check("mrst_valid", 32'(valid_o), 32'h0);
    run_op("divu_one", DIVU_, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
